// File: rtl/if_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_fetch
// Description : IF-stage PC register and req/ack instruction-fetch controller.
//               Optional retired-fetch counter enabled by IF_FETCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_TOP   = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [31:0] NextPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_IF,
  output logic        instr_valid,
  output logic [4:0]  ExcCode_IF,
  output logic [31:0] fetch_count
);

  localparam logic [4:0]  c_EXC_NONE = 5'd0;
  localparam logic [4:0]  c_EXC_ADEL = 5'd4;
  localparam logic [31:0] c_TOP_WORD = IMEM_TOP - 32'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drain_addr, w_drain_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [4:0]  r_exc_code, w_exc_code_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_bad;
  logic        w_req;

  assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc < IMEM_BASE) || (r_pc > c_TOP_WORD);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_instr_nxt      = r_instr;
    w_exc_code_nxt   = r_exc_code;
    w_valid_nxt      = r_valid;
    w_req            = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_req = !w_bad;
        if (exc_req) begin
          w_pc_nxt       = EXC_VECTOR;
          w_valid_nxt    = 1'b0;
          w_instr_nxt    = 32'h0;
          w_exc_code_nxt = c_EXC_NONE;
          // An unacknowledged request must still complete before refetching.
          if (!w_bad && !imem_ack) begin
            w_state_nxt      = S_DRAIN;
            w_drain_addr_nxt = r_pc;
          end
        end else if (w_bad) begin
          w_instr_nxt    = 32'h0;
          w_exc_code_nxt = c_EXC_ADEL;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_HOLD;
        end else if (imem_ack) begin
          w_instr_nxt    = imem_rdata;
          w_exc_code_nxt = c_EXC_NONE;
          w_valid_nxt    = 1'b1;
          if (stall) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_pc_nxt = NextPC;
          end
        end else begin
          w_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        if (exc_req) begin
          w_pc_nxt       = EXC_VECTOR;
          w_valid_nxt    = 1'b0;
          w_instr_nxt    = 32'h0;
          w_exc_code_nxt = c_EXC_NONE;
          w_state_nxt    = S_FETCH;
        end else if (!stall) begin
          w_pc_nxt    = NextPC;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end

      S_DRAIN: begin
        w_req = 1'b1;
        if (exc_req) begin
          w_pc_nxt       = EXC_VECTOR;
          w_valid_nxt    = 1'b0;
          w_instr_nxt    = 32'h0;
          w_exc_code_nxt = c_EXC_NONE;
        end
        if (imem_ack) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_instr      <= 32'h0;
      r_exc_code   <= c_EXC_NONE;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_instr      <= w_instr_nxt;
      r_exc_code   <= w_exc_code_nxt;
      r_valid      <= w_valid_nxt;
    end
  end

  // Gated by reset so an in-flight request is withdrawn the moment reset asserts.
  assign imem_req    = reset & w_req;
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign PC_IF       = r_pc;
  assign Instr_IF    = r_instr;
  assign instr_valid = r_valid;
  assign ExcCode_IF  = r_exc_code;

`ifdef IF_FETCH_COUNT_EN
  logic        w_accept;
  logic [31:0] r_fetch_count;

  assign w_accept = (r_state == S_FETCH) && !w_bad && imem_ack && !exc_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 32'h0;
`endif

endmodule
`default_nettype wire
